// File: rtl/encoder_xnor_layer_if.sv
// Bundles the activation, weight-write, result and sequence-status signals of
// encoder_xnor_layer. The master modport is the driving environment; the slave
// modport is the layer itself.
interface encoder_xnor_layer_if #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_N   = 256,
  parameter int unsigned NUM_BLK = 4,
  parameter int unsigned T_STEPS = 30
);
  localparam int unsigned BLK_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int unsigned IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int unsigned CNT_W = $clog2(T_STEPS + 1);

  logic             start;
  logic [IN_W-1:0]  data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [BLK_W-1:0] block_sel;
  logic             w_wr_en;
  logic [BLK_W-1:0] w_wr_blk;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IN_W-1:0]  w_wr_data;
  logic [OUT_N-1:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready;
  logic [CNT_W-1:0] step_cnt;
  logic             done;

  modport master (
    output start, data_in, data_in_valid, block_sel,
    output w_wr_en, w_wr_blk, w_wr_idx, w_wr_data, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, step_cnt, done
  );

  modport slave (
    input  start, data_in, data_in_valid, block_sel,
    input  w_wr_en, w_wr_blk, w_wr_idx, w_wr_data, data_out_ready,
    output data_in_ready, data_out, data_out_valid, step_cnt, done
  );
endinterface

// File: rtl/encoder_xnor_layer.sv
// Binary (XNOR/popcount) neuron layer: each accepted input word is compared
// against one bank of OUT_N weight words; every neuron fires when enough bits
// agree. Two-stage pipeline (operand capture, result register) with a
// valid/ready handshake on both sides and a step counter that ends a sequence.
module encoder_xnor_layer #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_N   = 256,
  parameter int unsigned NUM_BLK = 4,
  parameter int unsigned T_STEPS = 30,
  parameter int unsigned THRESH  = IN_W / 2,
  parameter int unsigned TIE_ONE = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  encoder_xnor_layer_if.slave  bus
);

  localparam int unsigned BLK_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int unsigned IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int unsigned CNT_W = $clog2(T_STEPS + 1);
  localparam int unsigned PC_W  = $clog2(IN_W + 1);

  // One extra bit so NUM_BLK / OUT_N themselves are representable.
  localparam logic [BLK_W:0]   NumBlkL = (BLK_W + 1)'(NUM_BLK);
  localparam logic [IDX_W:0]   OutNL   = (IDX_W + 1)'(OUT_N);
  localparam logic [CNT_W-1:0] TStepsL = CNT_W'(T_STEPS);

  // Neuron decision: unsigned count of agreeing bits against the threshold.
  function automatic logic neuron_fire(input logic [IN_W-1:0] w, input logic [IN_W-1:0] x);
    logic [IN_W-1:0] agree;
    logic [PC_W-1:0] pc;
    agree = ~(w ^ x);
    pc    = '0;
    for (int j = 0; j < IN_W; j++) begin
      pc = pc + PC_W'(agree[j]);
    end
    if (TIE_ONE != 0) begin
      return 32'(pc) >= THRESH;
    end
    return 32'(pc) > THRESH;
  endfunction

  logic [IN_W-1:0]  w_mem [NUM_BLK][OUT_N];
  logic [IN_W-1:0]  bank_rd [OUT_N];
  logic [IN_W-1:0]  bank_a_q [OUT_N];
  logic [IN_W-1:0]  data_a_q;
  logic             blk_ok_a_q;
  logic             valid_a_q, valid_a_d;
  logic             valid_b_q, valid_b_d;
  logic [OUT_N-1:0] data_out_q, result_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             done_q, done_d;
  logic             in_ready, in_fire, out_fire, load_b;
  logic             blk_ok_in, wr_ok;

  assign blk_ok_in = ({1'b0, bus.block_sel} < NumBlkL);
  assign wr_ok     = bus.w_wr_en && ({1'b0, bus.w_wr_blk} < NumBlkL) &&
                     ({1'b0, bus.w_wr_idx} < OutNL);

  // Handshake decode; start blocks new input and wins over any handshake.
  always_comb begin
    load_b   = valid_a_q & (~valid_b_q | bus.data_out_ready);
    out_fire = valid_b_q & bus.data_out_ready;
    in_ready = (~valid_a_q | load_b) & ~done_q & ~bus.start;
    in_fire  = bus.data_in_valid & in_ready;
  end

  // Next state for the pipeline valids, step counter and done flag.
  always_comb begin
    valid_a_d  = valid_a_q;
    valid_b_d  = valid_b_q;
    step_cnt_d = step_cnt_q;
    done_d     = done_q;
    if (bus.start) begin
      valid_a_d  = 1'b0;
      valid_b_d  = 1'b0;
      step_cnt_d = '0;
      done_d     = 1'b0;
    end else begin
      if (in_fire) begin
        valid_a_d = 1'b1;
      end else if (load_b) begin
        valid_a_d = 1'b0;
      end
      if (load_b) begin
        valid_b_d = 1'b1;
      end else if (out_fire) begin
        valid_b_d = 1'b0;
      end
      if (out_fire && (step_cnt_q != TStepsL)) begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
      end
      done_d = done_q | (step_cnt_d == TStepsL);
    end
  end

  // Bank read for the selected block; an absent block reads as zero.
  always_comb begin
    for (int i = 0; i < OUT_N; i++) begin
      bank_rd[i] = blk_ok_in ? w_mem[bus.block_sel][i] : '0;
    end
  end

  // Neuron outputs from the captured operands; invalid block forces all-zero.
  always_comb begin
    result_d = '0;
    for (int i = 0; i < OUT_N; i++) begin
      result_d[i] = blk_ok_a_q & neuron_fire(bank_a_q[i], data_a_q);
    end
  end

  // Weight storage: not reset, untouched by start; a same-edge read sees old data.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      w_mem[bus.w_wr_blk][bus.w_wr_idx] <= bus.w_wr_data;
    end
  end

  // Stage A operand capture on input handshake; qualified by valid_a_q.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_a_q   <= bus.data_in;
      blk_ok_a_q <= blk_ok_in;
      for (int i = 0; i < OUT_N; i++) begin
        bank_a_q[i] <= bank_rd[i];
      end
    end
  end

  // Control state and stage B result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      data_out_q <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
      if (load_b && !bus.start) begin
        data_out_q <= result_d;
      end
    end
  end

  assign bus.data_in_ready  = in_ready;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = valid_b_q;
  assign bus.step_cnt       = step_cnt_q;
  assign bus.done           = done_q;

endmodule
